// File: rtl/clic_entry_regs_if.sv
// -----------------------------------------------------------------------------
// clic_entry_regs_if
// Software configuration and core claim bus for clic_entry_regs.
//
// Signals
//   cfg_we       config write strobe
//   cfg_addr     target entry index
//   cfg_field    0=prio, 1=enable, 2=trig (1=edge), 3=pending
//   cfg_wdata    write data; fields 1..3 use bit 0 only
//   cfg_re       config read strobe
//   cfg_rdata    {trig, enable, pending, prio} of the addressed entry, registered
//   cfg_rvalid   cfg_rdata valid, pulses one cycle after cfg_re
//   claim_valid  core accepted the interrupt at claim_index
//   claim_index  claimed entry (the arbiter's winning index)
//
// Modports
//   master  drives the strobes, address, data and claim; receives read data
//   slave   the entry register block
// -----------------------------------------------------------------------------
interface clic_entry_regs_if;

   localparam int NR_INDEX_BITS = 3;
   localparam int NR_PRIO_BITS  = 3;

   logic                      cfg_we;
   logic [NR_INDEX_BITS-1:0]  cfg_addr;
   logic [1:0]                cfg_field;
   logic [NR_PRIO_BITS-2:0]   cfg_wdata;
   logic                      cfg_re;
   logic [NR_PRIO_BITS+1:0]   cfg_rdata;
   logic                      cfg_rvalid;
   logic                      claim_valid;
   logic [NR_INDEX_BITS-1:0]  claim_index;

   modport master (
      output cfg_we,
      output cfg_addr,
      output cfg_field,
      output cfg_wdata,
      output cfg_re,
      input  cfg_rdata,
      input  cfg_rvalid,
      output claim_valid,
      output claim_index
   );

   modport slave (
      input  cfg_we,
      input  cfg_addr,
      input  cfg_field,
      input  cfg_wdata,
      input  cfg_re,
      output cfg_rdata,
      output cfg_rvalid,
      input  claim_valid,
      input  claim_index
   );

endinterface

// File: rtl/clic_entry_regs.sv
// -----------------------------------------------------------------------------
// clic_entry_regs
// Per-interrupt state store that feeds the CAN-style CLIC arbiter. Each source
// keeps a priority, an enable, a trigger mode (level or edge) and a pending
// bit. Edge-mode sources latch rising edges into pending, which is cleared
// when the core claims the entry. Level-mode sources simply mirror the line.
//
// Ports
//   clk         single clock, all state updates on the rising edge
//   rst_n       synchronous, active-low reset
//   irq_src     raw interrupt lines, synchronous to clk
//   bus         config read/write port and core claim (slave modport)
//   entries     per-source arbiter entry: active ? {1'b1, prio} : '0
//   any_active  OR of all active flags, qualifies the arbiter output
// -----------------------------------------------------------------------------
module clic_entry_regs (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [7:0]                  irq_src,
   clic_entry_regs_if.slave            bus,
   output logic [7:0][2:0]             entries,
   output logic                        any_active
);

   localparam int NR_INDEX_BITS = 3;
   localparam int NR_PRIO_BITS  = 3;
   localparam int N             = 2 ** NR_INDEX_BITS;
   localparam int PW            = NR_PRIO_BITS - 1;

   localparam logic [1:0] FIELD_PRIO    = 2'd0;
   localparam logic [1:0] FIELD_ENABLE  = 2'd1;
   localparam logic [1:0] FIELD_TRIG    = 2'd2;
   localparam logic [1:0] FIELD_PENDING = 2'd3;

   logic [N-1:0][PW-1:0]       prio_q,    prio_d;
   logic [N-1:0]               enable_q,  enable_d;
   logic [N-1:0]               trig_q,    trig_d;
   logic [N-1:0]               pending_q, pending_d;
   logic [N-1:0]               irq_q,     irq_d;
   logic [NR_PRIO_BITS+1:0]    rdata_q,   rdata_d;
   logic                       rvalid_q,  rvalid_d;

   logic [N-1:0]               wr_sel;
   logic [N-1:0]               claim_sel;
   logic [N-1:0]               rise;
   logic [N-1:0]               active;

   // Next-state for all entries. Pending in edge mode resolves in strict
   // priority: software write, then a fresh rising edge, then a claim, so a
   // new edge landing on the claim cycle is never lost. Level mode ignores
   // both claim and software pending writes and just follows the line.
   always_comb begin
      prio_d    = prio_q;
      enable_d  = enable_q;
      trig_d    = trig_q;
      pending_d = pending_q;
      irq_d     = irq_src;
      rdata_d   = rdata_q;
      rvalid_d  = bus.cfg_re;
      wr_sel    = '0;
      claim_sel = '0;
      rise      = irq_src & ~irq_q;

      for (int i = 0; i < N; i++) begin
         wr_sel[i]    = bus.cfg_we && (bus.cfg_addr == NR_INDEX_BITS'(i));
         claim_sel[i] = bus.claim_valid && (bus.claim_index == NR_INDEX_BITS'(i));

         if (wr_sel[i]) begin
            case (bus.cfg_field)
               FIELD_PRIO:   prio_d[i]   = bus.cfg_wdata;
               FIELD_ENABLE: enable_d[i] = bus.cfg_wdata[0];
               FIELD_TRIG:   trig_d[i]   = bus.cfg_wdata[0];
               default:      ;
            endcase
         end

         if (trig_q[i]) begin
            if (wr_sel[i] && (bus.cfg_field == FIELD_PENDING)) begin
               pending_d[i] = bus.cfg_wdata[0];
            end else if (rise[i]) begin
               pending_d[i] = 1'b1;
            end else if (claim_sel[i]) begin
               pending_d[i] = 1'b0;
            end
         end else begin
            pending_d[i] = irq_src[i];
         end
      end

      // Readback samples the current registers, so a same-cycle write is
      // reported with its pre-write value.
      if (bus.cfg_re) begin
         rdata_d = {trig_q[bus.cfg_addr], enable_q[bus.cfg_addr],
                    pending_q[bus.cfg_addr], prio_q[bus.cfg_addr]};
      end
   end

   // State registers with synchronous active-low reset. irq_q tracks the
   // line in every mode so switching to edge mode with a held-high source
   // does not fabricate an edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prio_q    <= '0;
         enable_q  <= '0;
         trig_q    <= '0;
         pending_q <= '0;
         irq_q     <= '0;
         rdata_q   <= '0;
         rvalid_q  <= 1'b0;
      end else begin
         prio_q    <= prio_d;
         enable_q  <= enable_d;
         trig_q    <= trig_d;
         pending_q <= pending_d;
         irq_q     <= irq_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
      end
   end

   // Arbiter-facing outputs are derived from registers only.
   always_comb begin
      active  = enable_q & pending_q;
      entries = '0;
      for (int i = 0; i < N; i++) begin
         if (active[i]) begin
            entries[i] = {1'b1, prio_q[i]};
         end
      end
   end

   assign any_active     = |active;
   assign bus.cfg_rdata  = rdata_q;
   assign bus.cfg_rvalid = rvalid_q;

endmodule

// File: tb/tb_clic_entry_regs.sv
// -----------------------------------------------------------------------------
// tb_clic_entry_regs
// Directed bench for clic_entry_regs: reset, edge/claim, edge-vs-claim race,
// level mode, enable gating, readback, trigger switching and mid-run reset.
// -----------------------------------------------------------------------------
module tb_clic_entry_regs;

   logic             clk;
   logic             rst_n;
   logic [7:0]       irq_src;
   logic [7:0][2:0]  entries;
   logic             any_active;

   int checkCount;
   int errorCount;

   clic_entry_regs_if bus ();

   clic_entry_regs dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .irq_src    (irq_src),
      .bus        (bus),
      .entries    (entries),
      .any_active (any_active)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and settle just past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive one bus cycle (write, read and/or claim), then release the strobes.
   task automatic applyStimulus(input logic we, input logic [2:0] addr,
                                input logic [1:0] field, input logic [1:0] wdata,
                                input logic re, input logic claimV,
                                input logic [2:0] claimI);
      bus.cfg_we      = we;
      bus.cfg_addr    = addr;
      bus.cfg_field   = field;
      bus.cfg_wdata   = wdata;
      bus.cfg_re      = re;
      bus.claim_valid = claimV;
      bus.claim_index = claimI;
      tick();
      bus.cfg_we      = 1'b0;
      bus.cfg_re      = 1'b0;
      bus.claim_valid = 1'b0;
   endtask

   task automatic cfgWrite(input logic [2:0] addr, input logic [1:0] field,
                           input logic [1:0] wdata);
      applyStimulus(1'b1, addr, field, wdata, 1'b0, 1'b0, 3'd0);
   endtask

   task automatic claim(input logic [2:0] idx);
      applyStimulus(1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b1, idx);
   endtask

   task automatic cfgRead(input logic [2:0] addr);
      applyStimulus(1'b0, addr, 2'd0, 2'd0, 1'b1, 1'b0, 3'd0);
   endtask

   initial begin
      checkCount      = 0;
      errorCount      = 0;
      rst_n           = 1'b0;
      irq_src         = 8'hFF;
      bus.cfg_we      = 1'b0;
      bus.cfg_addr    = '0;
      bus.cfg_field   = '0;
      bus.cfg_wdata   = '0;
      bus.cfg_re      = 1'b0;
      bus.claim_valid = 1'b0;
      bus.claim_index = '0;

      // Reset with every source high.
      tick();
      tick();
      checkOutput("rst_entries", 32'(entries), 32'h0);
      checkOutput("rst_any", 32'(any_active), 32'h0);
      checkOutput("rst_rvalid", 32'(bus.cfg_rvalid), 32'h0);
      checkOutput("rst_rdata", 32'(bus.cfg_rdata), 32'h0);
      irq_src = 8'h00;
      rst_n   = 1'b1;
      tick();

      // Edge mode, then claim.
      cfgWrite(3'd5, 2'd0, 2'b10);
      cfgWrite(3'd5, 2'd1, 2'b01);
      cfgWrite(3'd5, 2'd2, 2'b01);
      checkOutput("edge_idle", 32'(entries[5]), 32'h0);
      irq_src[5] = 1'b1;
      tick();
      checkOutput("edge_set", 32'(entries[5]), 32'b110);
      checkOutput("edge_any", 32'(any_active), 32'h1);
      irq_src[5] = 1'b0;
      claim(3'd5);
      checkOutput("edge_claim", 32'(entries[5]), 32'h0);
      checkOutput("edge_claim_any", 32'(any_active), 32'h0);

      // Rising edge on the same cycle as a claim keeps the entry pending.
      cfgWrite(3'd2, 2'd0, 2'b01);
      cfgWrite(3'd2, 2'd1, 2'b01);
      cfgWrite(3'd2, 2'd2, 2'b01);
      cfgWrite(3'd2, 2'd3, 2'b01);
      checkOutput("sim_pend", 32'(entries[2]), 32'b101);
      irq_src[2] = 1'b1;
      claim(3'd2);
      checkOutput("sim_race", 32'(entries[2]), 32'b101);
      claim(3'd2);
      checkOutput("sim_held_claim", 32'(entries[2]), 32'h0);
      irq_src[2] = 1'b0;
      tick();

      // Level mode follows the line and ignores claims and pending writes.
      cfgWrite(3'd1, 2'd0, 2'b01);
      cfgWrite(3'd1, 2'd1, 2'b01);
      irq_src[1] = 1'b1;
      tick();
      checkOutput("lvl_set", 32'(entries[1]), 32'b101);
      claim(3'd1);
      checkOutput("lvl_claim", 32'(entries[1]), 32'b101);
      irq_src[1] = 1'b0;
      tick();
      checkOutput("lvl_drop", 32'(entries[1]), 32'h0);
      cfgWrite(3'd1, 2'd3, 2'b01);
      checkOutput("lvl_pendwr", 32'(entries[1]), 32'h0);

      // Enable gate: pending but disabled stays invisible.
      cfgWrite(3'd7, 2'd2, 2'b01);
      cfgWrite(3'd7, 2'd0, 2'b11);
      cfgWrite(3'd7, 2'd3, 2'b01);
      checkOutput("gate_off", 32'(entries[7]), 32'h0);
      checkOutput("gate_off_any", 32'(any_active), 32'h0);
      cfgWrite(3'd7, 2'd1, 2'b01);
      checkOutput("gate_on", 32'(entries[7]), 32'b111);
      checkOutput("gate_on_any", 32'(any_active), 32'h1);
      cfgWrite(3'd7, 2'd1, 2'b00);
      checkOutput("gate_reoff", 32'(entries[7]), 32'h0);
      cfgRead(3'd7);
      checkOutput("gate_keep_pend", 32'(bus.cfg_rdata), 32'b10111);
      cfgWrite(3'd7, 2'd3, 2'b00);

      // Readback, including pre-write value on a same-cycle write.
      cfgWrite(3'd3, 2'd0, 2'b11);
      cfgRead(3'd3);
      checkOutput("rd_valid", 32'(bus.cfg_rvalid), 32'h1);
      checkOutput("rd_prio", 32'(bus.cfg_rdata[1:0]), 32'b11);
      tick();
      checkOutput("rd_pulse", 32'(bus.cfg_rvalid), 32'h0);
      applyStimulus(1'b1, 3'd3, 2'd0, 2'b00, 1'b1, 1'b0, 3'd0);
      checkOutput("rd_prewrite", 32'(bus.cfg_rdata), 32'b00011);
      cfgRead(3'd3);
      checkOutput("rd_postwrite", 32'(bus.cfg_rdata), 32'b00000);

      // Level to edge with the line held high must not self-trigger.
      cfgWrite(3'd6, 2'd0, 2'b10);
      cfgWrite(3'd6, 2'd1, 2'b01);
      irq_src[6] = 1'b1;
      tick();
      checkOutput("sw_level", 32'(entries[6]), 32'b110);
      cfgWrite(3'd6, 2'd2, 2'b01);
      claim(3'd6);
      checkOutput("sw_claim", 32'(entries[6]), 32'h0);
      tick();
      checkOutput("sw_no_self", 32'(entries[6]), 32'h0);

      // Mid-run reset discards pending; after release the entry is level/disabled.
      irq_src[6] = 1'b0;
      tick();
      irq_src[6] = 1'b1;
      tick();
      checkOutput("mr_pend", 32'(entries[6]), 32'b110);
      rst_n = 1'b0;
      tick();
      checkOutput("mr_rst", 32'(entries), 32'h0);
      rst_n = 1'b1;
      tick();
      checkOutput("mr_after_any", 32'(any_active), 32'h0);
      cfgRead(3'd6);
      checkOutput("mr_after_rd", 32'(bus.cfg_rdata), 32'b00100);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
